three_bit_pattern_out: RTL and testbench
========================================

// Module: three_bit_pattern_out
// PURPOSE
//  Free-running 3-bit pattern generator on three FPGA->RP2040 host pins (top/middle/bottom).
//  Steps through a fixed pattern sequence, holding each pattern STEP_CYCLES clocks.
//  Gives the host a known, slowly changing test pattern; the top level can loop the
//  same pins back to the RGB LED.
// PARAMETERS
//  STEP_CYCLES  12_000_000  clocks per pattern (>=1; default = 1 s at 12 MHz)
//  MODE         0           sequence: 0=binary count, 1=Gray code, 2=walking one
// PORTS
//  clk     in   1  system clock, single clock domain, rising edge
//  rst     in   1  reset, asynchronous, active-high
//  top     out  1  pattern bit 2 (MSB)
//  middle  out  1  pattern bit 1
//  bottom  out  1  pattern bit 0 (LSB)
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-high.
//  - State:
//    - pre: prescaler, width max(1,$clog2(STEP_CYCLES)).
//    - step: 3-bit index.
//    - pat: 3-bit registered output; {top,middle,bottom} = pat.
//  - Reset (async assert, sync to clk on release): pre=0, step=0, pat=PAT(0).
//    - Output reset values: MODE 0/1 -> 000; MODE 2 -> 001.
//  - Prescaler: tick = (pre == STEP_CYCLES-1).
//    - On tick: pre<=0. Otherwise pre<=pre+1.
//    - STEP_CYCLES=1 -> tick every clock.
//  - On tick: step<=step_nxt and pat<=PAT(step_nxt) on the same edge.
//    - Outputs are glitch-free registers; no combinational path to the pins.
//  - PAT(s) by MODE:
//    - MODE 0: s. step_nxt = s+1 mod 8 (000..111, then 000).
//    - MODE 1: s ^ (s>>1). step_nxt = s+1 mod 8 (000,001,011,010,110,111,101,100, then 000).
//    - MODE 2: 3'b001 << s. step_nxt = (s==2) ? 0 : s+1 (001,010,100, then 001).
//  - Timing:
//    - First change occurs at the STEP_CYCLES-th rising edge after reset release.
//    - Each pattern is held exactly STEP_CYCLES clocks; sequence period 8*STEP_CYCLES (MODE 2: 3*STEP_CYCLES).
//  - Reset mid-step: immediately forces the reset state. Counting restarts from pre=0 after release.
//  - Illegal MODE (>2): behave as MODE 0.
//  - No inputs besides clk/rst; no handshake; runs continuously.
// STRUCTURE
//  - Shared package (pattern_pkg):
//    - localparams MODE_BIN=0, MODE_GRAY=1, MODE_WALK=2.
//    - function pat_of(mode, step) returning 3 bits.
//  - Sub-module tick_gen #(.DIV(STEP_CYCLES)) (clk, rst, tick): prescaler with one-cycle tick pulse.
//  - Top holds the step counter and output register.
// TESTING (STEP_CYCLES=4 unless noted)
//  1. Reset, MODE 0: rst=1 -> outputs 000 within the same cycle.
//     Release -> 000 for 4 clocks, then 001, 010, ..., 111, then 000. Each value held exactly 4 clocks.
//  2. MODE 1: sampled sequence 000,001,011,010,110,111,101,100,000.
//     Exactly one output bit toggles per step.
//  3. MODE 2: reset value 001; sequence 001,010,100,001.
//     Exactly one bit is high at every sample.
//  4. STEP_CYCLES=1, MODE 0: outputs increment every clock, 000..111, wrapping after 8 clocks.
//  5. Async reset mid-step: assert rst between clock edges while pat=101.
//     -> outputs 000 before the next edge.
//     After release, the next change occurs exactly 4 clocks later.
//  6. Long run: MODE 0 for 1000 steps. Check period = 32 clocks and no X/glitch on top/middle/bottom.

Source files
------------

// File: rtl/three_bit_pattern_out_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : three_bit_pattern_out_pkg
//  Description : Shared mode encodings and pattern helper functions for the
//                three-bit host pattern generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package three_bit_pattern_out_pkg;

    localparam int unsigned MODE_BIN  = 0;
    localparam int unsigned MODE_GRAY = 1;
    localparam int unsigned MODE_WALK = 2;

    // Sequence length per mode; unknown modes fall back to the binary count.
    localparam int unsigned SEQ_LEN_FULL = 8;
    localparam int unsigned SEQ_LEN_WALK = 3;

    // Pattern driven on the pins for a given step index.
    function automatic logic [2:0] pat_of(input int unsigned mode, input logic [2:0] step);
        logic [2:0] r;
        case (mode)
            MODE_GRAY: r = step ^ (step >> 1);
            MODE_WALK: r = 3'b001 << step;
            default:   r = step;
        endcase
        return r;
    endfunction

    // Step index that follows the given one; the walking-one wraps after three steps.
    function automatic logic [2:0] step_nxt(input int unsigned mode, input logic [2:0] step);
        logic [2:0] r;
        case (mode)
            MODE_WALK: r = (step == 3'd2) ? 3'd0 : step + 3'd1;
            default:   r = step + 3'd1;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/three_bit_pattern_out_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tick_gen
//  Description : Free-running prescaler producing a one-cycle tick every DIV
//                clocks. DIV=1 yields a tick on every clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    // One extra bit is never needed: the counter only reaches DIV-1.
    localparam int unsigned  W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] pre_q;
    logic [W-1:0] pre_d;

    assign tick = (pre_q == LAST);

    // Next prescaler value: wrap to zero on the tick, otherwise count up.
    always_comb begin
        pre_d = tick ? '0 : pre_q + 1'b1;
    end

    // Prescaler register, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/three_bit_pattern_out.sv
`default_nettype none
// ============================================================================
//  Module      : three_bit_pattern_out
//  Description : Free-running 3-bit test pattern on the top/middle/bottom host
//                pins. Each pattern is held STEP_CYCLES clocks; the sequence is
//                binary count, Gray code or walking one depending on MODE.
//  Revision    : 1.0 - initial release
// ============================================================================
module three_bit_pattern_out
    import three_bit_pattern_out_pkg::*;
#(
    parameter int unsigned STEP_CYCLES = 12_000_000,
    parameter int unsigned MODE        = 0
) (
    input  logic clk,
    input  logic rst,
    output logic top,
    output logic middle,
    output logic bottom
);

    // Out-of-range modes are folded onto the binary count once, here.
    localparam int unsigned EFF_MODE = (MODE > MODE_WALK) ? MODE_BIN : MODE;

    logic       tick;
    logic [2:0] step_q;
    logic [2:0] step_d;
    logic [2:0] pat_q;
    logic [2:0] pat_d;

    tick_gen #(
        .DIV (STEP_CYCLES)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Pattern is computed from the next step so both registers move on the same edge.
    always_comb begin
        step_d = step_nxt(EFF_MODE, step_q);
        pat_d  = pat_of(EFF_MODE, step_d);
    end

    // Step index and pin register; pins come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q <= 3'd0;
            pat_q  <= pat_of(EFF_MODE, 3'd0);
        end else if (tick) begin
            step_q <= step_d;
            pat_q  <= pat_d;
        end
    end

    assign top    = pat_q[2];
    assign middle = pat_q[1];
    assign bottom = pat_q[0];

endmodule
`default_nettype wire

// File: tb/tb_three_bit_pattern_out.sv
`default_nettype none
// ============================================================================
//  Module      : tb_three_bit_pattern_out
//  Description : Self-checking bench for three_bit_pattern_out. Runs binary,
//                Gray, walking-one, fast (STEP_CYCLES=1) and illegal-mode
//                instances side by side from a shared clock and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_three_bit_pattern_out;

    logic clk;
    logic rst;

    logic bin_t,  bin_m,  bin_b;
    logic gray_t, gray_m, gray_b;
    logic walk_t, walk_m, walk_b;
    logic fast_t, fast_m, fast_b;
    logic bad_t,  bad_m,  bad_b;

    int n_checks;
    int n_errors;

    // Hand-written expected sequences.
    logic [2:0] gray_tbl [8];
    logic [2:0] walk_tbl [3];

    three_bit_pattern_out #(.STEP_CYCLES(4), .MODE(0)) u_bin (
        .clk(clk), .rst(rst), .top(bin_t), .middle(bin_m), .bottom(bin_b));
    three_bit_pattern_out #(.STEP_CYCLES(4), .MODE(1)) u_gray (
        .clk(clk), .rst(rst), .top(gray_t), .middle(gray_m), .bottom(gray_b));
    three_bit_pattern_out #(.STEP_CYCLES(4), .MODE(2)) u_walk (
        .clk(clk), .rst(rst), .top(walk_t), .middle(walk_m), .bottom(walk_b));
    three_bit_pattern_out #(.STEP_CYCLES(1), .MODE(0)) u_fast (
        .clk(clk), .rst(rst), .top(fast_t), .middle(fast_m), .bottom(fast_b));
    three_bit_pattern_out #(.STEP_CYCLES(4), .MODE(3)) u_bad (
        .clk(clk), .rst(rst), .top(bad_t), .middle(bad_m), .bottom(bad_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [2:0] got, input logic [2:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Check all instances for reset values right now.
    task automatic check_reset(input string tag);
        check_eq({tag, "_bin"},  {bin_t,  bin_m,  bin_b},  3'b000);
        check_eq({tag, "_gray"}, {gray_t, gray_m, gray_b}, 3'b000);
        check_eq({tag, "_walk"}, {walk_t, walk_m, walk_b}, 3'b001);
        check_eq({tag, "_fast"}, {fast_t, fast_m, fast_b}, 3'b000);
        check_eq({tag, "_bad"},  {bad_t,  bad_m,  bad_b},  3'b000);
    endtask

    // Called at the negedge right after reset release; sample k sits after k rising edges.
    task automatic run_seq(input string tag, input int n);
        logic [2:0] walk_now;
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin
                @(posedge clk);
                @(negedge clk);
            end
            walk_now = {walk_t, walk_m, walk_b};
            check_eq($sformatf("%s_bin_k%0d", tag, k),  {bin_t, bin_m, bin_b},    3'((k / 4) % 8));
            check_eq($sformatf("%s_gray_k%0d", tag, k), {gray_t, gray_m, gray_b}, gray_tbl[(k / 4) % 8]);
            check_eq($sformatf("%s_walk_k%0d", tag, k), walk_now,                 walk_tbl[(k / 4) % 3]);
            check_eq($sformatf("%s_onehot_k%0d", tag, k), 3'($countones(walk_now)), 3'd1);
            check_eq($sformatf("%s_fast_k%0d", tag, k), {fast_t, fast_m, fast_b}, 3'(k % 8));
            check_eq($sformatf("%s_bad_k%0d", tag, k),  {bad_t, bad_m, bad_b},    3'((k / 4) % 8));
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        gray_tbl = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
        walk_tbl = '{3'b001, 3'b010, 3'b100};

        // Assert reset between edges; outputs must settle before the first clock edge.
        rst = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_reset("async_rst");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("rst_held");
        rst = 1'b0;

        // Sequences through 101 on the binary instance (k=20,21).
        run_seq("seq", 22);
        check_eq("bin_at_101", {bin_t, bin_m, bin_b}, 3'b101);

        // Mid-step asynchronous reset, checked before the next rising edge.
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset("mid_rst");
        @(negedge clk);
        rst = 1'b0;

        // Restart from pre=0 then long run: 1000 binary steps of 4 clocks each.
        run_seq("long", 4001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
